// File: rtl/spi_ctrl_pkg.sv
// Shared types and widths for the SPI frame scheduler and its arbiter.
package spi_ctrl_pkg;

    localparam int SPI_NCLIENT = 2;
    localparam int BYTE_W      = 8;
    localparam int LEN_W       = 4;
    localparam int DIV_W       = 16;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_GAP,
        ST_HOLD,
        ST_CSIDLE
    } state_e;

    function automatic logic [SPI_NCLIENT-1:0] client_onehot(input logic c);
        return {c, ~c};
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-client grant logic: round-robin when SPI_XFER_SCHED_RR_EN is defined, else fixed priority to client 0.
module spi_rr_arb2
    import spi_ctrl_pkg::*;
(
    input  logic [SPI_NCLIENT-1:0] req,
`ifdef SPI_XFER_SCHED_RR_EN
    input  logic                   last_grant,
`endif
    output logic                   gnt_vld,
    output logic                   gnt
);

    always_comb begin
        gnt_vld = |req;
`ifdef SPI_XFER_SCHED_RR_EN
        // On contention the client that was not served last wins.
        unique case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
`else
        gnt = ~req[0];
`endif
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Frame scheduler in front of spi_master: arbitration, CS timing and byte sequencing.
// Macro SPI_XFER_SCHED_RR_EN selects round-robin arbitration (default: fixed priority).
module spi_xfer_sched
    import spi_ctrl_pkg::*;
#(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 2
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic [SPI_NCLIENT-1:0]         req,
    input  logic [SPI_NCLIENT*LEN_W-1:0]   len,
    input  logic [SPI_NCLIENT*DIV_W-1:0]   cfg_div,
    input  logic [SPI_NCLIENT*BYTE_W-1:0]  tx_data,
    output logic [SPI_NCLIENT-1:0]         tx_rd,
    output logic [BYTE_W-1:0]              rx_data,
    output logic [SPI_NCLIENT-1:0]         rx_vld,
    output logic [SPI_NCLIENT-1:0]         done,
    output logic                           busy,
    output logic                           spi_cs_ctrl,
    output logic [DIV_W-1:0]               spi_clk_div_val,
    output logic                           spi_wr_req,
    input  logic                           spi_wr_ack,
    output logic [BYTE_W-1:0]              spi_data_tx,
    input  logic [BYTE_W-1:0]              spi_data_rx
);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [LEN_W-1:0]        byte_cnt_q;
    logic                    g_q;
    logic                    cs_q;
    logic                    wr_req_q;
    logic                    busy_q;
    logic [SPI_NCLIENT-1:0]  tx_rd_q;
    logic [SPI_NCLIENT-1:0]  rx_vld_q;
    logic [SPI_NCLIENT-1:0]  done_q;
    logic [BYTE_W-1:0]       rx_data_q;
    logic [BYTE_W-1:0]       data_tx_q;
    logic [DIV_W-1:0]        div_q;
    logic                    gnt_vld;
    logic                    gnt;

`ifdef SPI_XFER_SCHED_RR_EN
    logic                    last_grant_q;

    spi_rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt        (gnt)
    );
`else
    spi_rr_arb2 u_arb (
        .req     (req),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: payload registers are reset too, so an aborted frame leaves no stale byte visible.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            g_q        <= 1'b0;
            cs_q       <= 1'b1;
            wr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_rd_q    <= '0;
            rx_vld_q   <= '0;
            done_q     <= '0;
            rx_data_q  <= '0;
            data_tx_q  <= '0;
            div_q      <= '0;
`ifdef SPI_XFER_SCHED_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            // NOTE: strobes default low every cycle; states below only raise them for one cycle.
            wr_req_q <= 1'b0;
            tx_rd_q  <= '0;
            rx_vld_q <= '0;
            done_q   <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        g_q        <= gnt;
                        byte_cnt_q <= len[LEN_W*int'(gnt) +: LEN_W];
                        div_q      <= cfg_div[DIV_W*int'(gnt) +: DIV_W];
                        cnt_q      <= CNT_W'(CS_SETUP);
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
`ifdef SPI_XFER_SCHED_RR_EN
                        last_grant_q <= gnt;
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        wr_req_q  <= 1'b1;
                        tx_rd_q   <= client_onehot(g_q);
                        data_tx_q <= tx_data[BYTE_W*int'(g_q) +: BYTE_W];
                        state_q   <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_LOAD: state_q <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (spi_wr_ack) begin
                        rx_data_q <= spi_data_rx;
                        rx_vld_q  <= client_onehot(g_q);
                        if (byte_cnt_q == '0) begin
                            cnt_q   <= CNT_W'(CS_HOLD);
                            state_q <= ST_HOLD;
                        end else begin
                            byte_cnt_q <= byte_cnt_q - LEN_W'(1);
                            state_q    <= ST_GAP;
                        end
                    end
                end
                // One idle cycle lets spi_master return to idle before the next request.
                ST_GAP: begin
                    wr_req_q  <= 1'b1;
                    tx_rd_q   <= client_onehot(g_q);
                    data_tx_q <= tx_data[BYTE_W*int'(g_q) +: BYTE_W];
                    state_q   <= ST_LOAD;
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cs_q    <= 1'b1;
                        cnt_q   <= CNT_W'(CS_IDLE);
                        state_q <= ST_CSIDLE;
                        if (CS_IDLE == 1) done_q <= client_onehot(g_q);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                // done is registered, so it is raised on entry to the last CSIDLE cycle.
                ST_CSIDLE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(2)) done_q <= client_onehot(g_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_rd           = tx_rd_q;
    assign rx_data         = rx_data_q;
    assign rx_vld          = rx_vld_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign spi_cs_ctrl     = cs_q;
    assign spi_clk_div_val = div_q;
    assign spi_wr_req      = wr_req_q;
    assign spi_data_tx     = data_tx_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched with a behavioural loopback spi_master and FWFT client sources.
module tb_spi_xfer_sched;
    import spi_ctrl_pkg::*;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_IDLE  = 2;
    localparam int ACK_LAT  = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  req;
    logic [7:0]  len;
    logic [31:0] cfg_div;
    logic [15:0] tx_data;
    logic [1:0]  tx_rd, rx_vld, done;
    logic [7:0]  rx_data;
    logic        busy, spi_cs_ctrl, spi_wr_req, spi_wr_ack;
    logic [15:0] spi_clk_div_val;
    logic [7:0]  spi_data_tx, spi_data_rx;

    spi_xfer_sched #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .len(len), .cfg_div(cfg_div),
        .tx_data(tx_data), .tx_rd(tx_rd), .rx_data(rx_data), .rx_vld(rx_vld), .done(done),
        .busy(busy), .spi_cs_ctrl(spi_cs_ctrl), .spi_clk_div_val(spi_clk_div_val),
        .spi_wr_req(spi_wr_req), .spi_wr_ack(spi_wr_ack), .spi_data_tx(spi_data_tx),
        .spi_data_rx(spi_data_rx)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Event logs filled by the monitor on the falling edge.
    int          wr_q[$], ack_q[$], rxv_q[$], done_cyc_q[$], cs_fall_q[$], cs_rise_q[$];
    logic [9:0]  rxb_q[$];
    logic [1:0]  done_vec_q[$];
    logic [15:0] div_q[$];
    int          txrd_cnt[2];
    int          pop[2];
    logic [7:0]  base[2];
    int          wr_consec_err = 0;
    int          stab_err = 0;
    int          pend = 0;
    logic [7:0]  lat_byte = '0;
    logic        prev_cs = 1'b1;
    logic        prev_wr = 1'b0;

    task automatic clear_logs();
        wr_q.delete(); ack_q.delete(); rxv_q.delete(); done_cyc_q.delete();
        cs_fall_q.delete(); cs_rise_q.delete(); rxb_q.delete(); done_vec_q.delete(); div_q.delete();
        txrd_cnt[0] = 0; txrd_cnt[1] = 0; pop[0] = 0; pop[1] = 0;
    endtask

    // Monitor, FWFT sources and loopback master (ack ACK_LAT cycles after wr_req).
    initial begin
        spi_wr_ack = 1'b0;
        spi_data_rx = '0;
        forever begin
            @(negedge sys_clk);
            if (spi_cs_ctrl !== prev_cs) begin
                if (spi_cs_ctrl === 1'b0) begin
                    cs_fall_q.push_back(cyc);
                    div_q.push_back(spi_clk_div_val);
                end else begin
                    cs_rise_q.push_back(cyc);
                end
            end
            prev_cs = spi_cs_ctrl;
            if (spi_wr_req === 1'b1 && prev_wr) wr_consec_err++;
            prev_wr = (spi_wr_req === 1'b1);
            if (|rx_vld) begin
                rxv_q.push_back(cyc);
                rxb_q.push_back({rx_vld, rx_data});
            end
            if (|done) begin
                done_cyc_q.push_back(cyc);
                done_vec_q.push_back(done);
            end
            for (int c = 0; c < 2; c++) begin
                if (tx_rd[c] === 1'b1) begin
                    txrd_cnt[c]++;
                    pop[c]++;
                end
            end
            tx_data = {8'(int'(base[1]) + pop[1]), 8'(int'(base[0]) + pop[0])};
            spi_wr_ack = 1'b0;
            if (sys_rst) begin
                pend = 0;
            end else begin
                if (pend > 0 && spi_data_tx !== lat_byte) stab_err++;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        spi_wr_ack = 1'b1;
                        spi_data_rx = lat_byte;
                        ack_q.push_back(cyc);
                    end
                end
                if (spi_wr_req === 1'b1) begin
                    lat_byte = spi_data_tx;
                    pend = ACK_LAT;
                    wr_q.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (done_cyc_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        if (done_cyc_q.size() < n) check({name, " timeout"}, 32'(done_cyc_q.size()), 32'(n));
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  len;
        logic [31:0] div;
        logic [7:0]  base;
        logic        exp_c;
        int          nbytes;
        logic [15:0] exp_div;
    } vec_t;

    vec_t vecs[6];

    int  n_req, t_ack, exp_order[4];
    logic [1:0] drop_n;

    initial begin
        vecs[0] = '{2'b01, 8'h00, {16'h0005, 16'h0003}, 8'hA5, 1'b0, 1,  16'h0003};
        vecs[1] = '{2'b10, 8'h30, {16'h0002, 16'h0007}, 8'h01, 1'b1, 4,  16'h0002};
        vecs[2] = '{2'b01, 8'h0F, {16'h1234, 16'hABCD}, 8'hF0, 1'b0, 16, 16'hABCD};
        vecs[3] = '{2'b10, 8'hF0, {16'hBEEF, 16'h0001}, 8'h10, 1'b1, 16, 16'hBEEF};
        vecs[4] = '{2'b01, 8'h12, {16'h5555, 16'h0A0A}, 8'h33, 1'b0, 3,  16'h0A0A};
        vecs[5] = '{2'b10, 8'h12, {16'h0100, 16'h0200}, 8'hC0, 1'b1, 2,  16'h0100};

        sys_rst = 1'b1; req = '0; len = '0; cfg_div = '0;
        base[0] = '0; base[1] = '0;
        clear_logs();
        repeat (3) tick();
        check("rst cs",      32'(spi_cs_ctrl), 1);
        check("rst strobes", {24'(0), tx_rd, rx_vld, done, spi_wr_req, busy}, 0);
        check("rst data",    {rx_data, spi_data_tx, spi_clk_div_val}, 0);
        sys_rst = 1'b0;
        tick();

        // Single byte, exact cycle timing.
        clear_logs();
        base[0] = 8'hA5; len = 8'h00; cfg_div = 32'h0000_0009; req = 2'b01;
        n_req = cyc;
        wait_dones(1, 200, "single");
        req = '0;
        tick();
        t_ack = ack_q.size() > 0 ? ack_q[0] : -100;
        check("single cs fall",  32'(cs_fall_q.size() > 0 ? cs_fall_q[0] - n_req : -1), 1);
        check("single wr count", 32'(wr_q.size()), 1);
        check("single wr time",  32'(wr_q.size() > 0 ? wr_q[0] - n_req : -1), 32'(1 + CS_SETUP));
        check("single rx",       32'(rxb_q.size() > 0 ? rxb_q[0] : 10'h3FF), {22'(0), 2'b01, 8'hA5});
        check("single rx time",  32'(rxv_q.size() > 0 ? rxv_q[0] : -1), 32'(t_ack + 1));
        check("single cs rise",  32'(cs_rise_q.size() > 0 ? cs_rise_q[0] : -1), 32'(t_ack + 1 + CS_HOLD));
        check("single done",     {30'(done_vec_q.size()), done_vec_q.size() > 0 ? done_vec_q[0] : 2'b00}, {30'(1), 2'b01});
        check("single done time", 32'(done_cyc_q.size() > 0 ? done_cyc_q[0] : -1), 32'(t_ack + CS_HOLD + CS_IDLE));
        check("single busy",     32'(busy), 0);

        // Table-driven single-client frames.
        foreach (vecs[v]) begin
            clear_logs();
            base[vecs[v].exp_c] = vecs[v].base; base[~vecs[v].exp_c] = 8'h00;
            len = vecs[v].len; cfg_div = vecs[v].div; req = vecs[v].req;
            wait_dones(1, 400, $sformatf("vec%0d", v));
            req = '0;
            repeat (2) tick();
            check($sformatf("vec%0d done", v), 32'(done_vec_q.size() > 0 ? done_vec_q[0] : 2'b00), 32'(client_onehot(vecs[v].exp_c)));
            check($sformatf("vec%0d tx_rd", v), {txrd_cnt[1][15:0], txrd_cnt[0][15:0]},
                  vecs[v].exp_c ? {16'(vecs[v].nbytes), 16'(0)} : {16'(0), 16'(vecs[v].nbytes)});
            check($sformatf("vec%0d rx count", v), 32'(rxb_q.size()), 32'(vecs[v].nbytes));
            for (int i = 0; i < rxb_q.size() && i < vecs[v].nbytes; i++)
                check($sformatf("vec%0d rx%0d", v, i), 32'(rxb_q[i]),
                      {22'(0), client_onehot(vecs[v].exp_c), 8'(int'(vecs[v].base) + i)});
            for (int i = 1; i < wr_q.size() && i <= ack_q.size(); i++)
                check($sformatf("vec%0d gap%0d", v, i), 32'(wr_q[i] - ack_q[i-1]), 2);
            check($sformatf("vec%0d cs edges", v), {16'(cs_fall_q.size()), 16'(cs_rise_q.size())}, {16'(1), 16'(1)});
            check($sformatf("vec%0d div", v), 32'(div_q.size() > 0 ? div_q[0] : 16'hDEAD), 32'(vecs[v].exp_div));
            check($sformatf("vec%0d busy", v), 32'(busy), 0);
        end

        // Simultaneous requests from a fresh reset (last grant = client 1).
        sys_rst = 1'b1; tick(); sys_rst = 1'b0; tick();
        clear_logs();
        base[0] = 8'h10; base[1] = 8'h20; len = 8'h00; cfg_div = {16'h0022, 16'h0011};
`ifdef SPI_XFER_SCHED_RR_EN
        exp_order = '{0, 1, 0, 1};
        drop_n = 2'd2;
`else
        exp_order = '{0, 0, 0, 1};
        drop_n = 2'd3;
`endif
        req = 2'b11;
        for (int i = 0; i < 600 && done_cyc_q.size() < 4; i++) begin
            int d0, d1;
            tick();
            d0 = 0; d1 = 0;
            foreach (done_vec_q[k]) begin
                if (done_vec_q[k][0]) d0++;
                if (done_vec_q[k][1]) d1++;
            end
            if (d0 >= int'(drop_n)) req[0] = 1'b0;
            if (d1 >= 4 - int'(drop_n)) req[1] = 1'b0;
        end
        req = '0;
        check("arb frames", 32'(done_vec_q.size()), 4);
        for (int i = 0; i < 4 && i < done_vec_q.size(); i++) begin
            check($sformatf("arb order%0d", i), 32'(done_vec_q[i]), 32'(client_onehot(exp_order[i] == 1)));
            check($sformatf("arb div%0d", i), 32'(div_q.size() > i ? div_q[i] : 16'hDEAD),
                  exp_order[i] == 1 ? 32'h0022 : 32'h0011);
        end
        repeat (3) tick();

        // Reset asserted while waiting for the ack of byte 2.
        clear_logs();
        base[0] = 8'h40; len = 8'h03; cfg_div = 32'h0000_0004; req = 2'b01;
        for (int i = 0; i < 100 && wr_q.size() < 2; i++) tick();
        check("rstmid reached byte2", 32'(wr_q.size()), 2);
        sys_rst = 1'b1; req = '0;
        tick();
        check("rstmid cs",      32'(spi_cs_ctrl), 1);
        check("rstmid outputs", {28'(0), spi_wr_req, busy, done}, 0);
        sys_rst = 1'b0;
        repeat (20) tick();
        check("rstmid no done", 32'(done_cyc_q.size()), 0);
        check("rstmid acks",    32'(ack_q.size()), 1);
        clear_logs();
        base[0] = 8'h50; req = 2'b01;
        wait_dones(1, 200, "rstmid fresh");
        req = '0;
        tick();
        check("rstmid fresh count", 32'(rxb_q.size()), 4);
        for (int i = 0; i < rxb_q.size() && i < 4; i++)
            check($sformatf("rstmid fresh rx%0d", i), 32'(rxb_q[i]), {22'(0), 2'b01, 8'(8'h50 + i)});

        // Back-to-back frames: req/len/cfg_div of client 1 change after its grant.
        clear_logs();
        base[1] = 8'h60; base[0] = 8'h70; len = 8'h10; cfg_div = {16'h0033, 16'h0044}; req = 2'b10;
        for (int i = 0; i < 50 && cs_fall_q.size() < 1; i++) tick();
        req = 2'b01; len[7:4] = 4'hF; cfg_div[31:16] = 16'hFFFF;
        wait_dones(2, 300, "gap");
        req = '0;
        tick();
        check("gap done0", 32'(done_vec_q.size() > 0 ? done_vec_q[0] : 2'b00), 32'b10);
        check("gap done1", 32'(done_vec_q.size() > 1 ? done_vec_q[1] : 2'b00), 32'b01);
        check("gap rx count", 32'(rxb_q.size()), 3);
        check("gap rx", {rxb_q.size() > 0 ? rxb_q[0] : 10'h0, rxb_q.size() > 1 ? rxb_q[1] : 10'h0, 12'(0)},
              {2'b10, 8'h60, 2'b10, 8'h61, 12'(0)});
        check("gap rx2", 32'(rxb_q.size() > 2 ? rxb_q[2] : 10'h0), {22'(0), 2'b01, 8'h70});
        check("gap div", {div_q.size() > 0 ? div_q[0] : 16'h0, div_q.size() > 1 ? div_q[1] : 16'h0}, 32'h0033_0044);
        check("gap cs high", 32'(cs_fall_q.size() > 1 && cs_rise_q.size() > 0 ? cs_fall_q[1] - cs_rise_q[0] : -1),
              32'(CS_IDLE + 1));
        check("gap done time", 32'(done_cyc_q.size() > 0 && cs_rise_q.size() > 0 ? done_cyc_q[0] - cs_rise_q[0] : -1),
              32'(CS_IDLE - 1));

        check("wr_req single cycle", 32'(wr_consec_err), 0);
        check("data_tx stable",      32'(stab_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

- Frame-level controller for the byte-wide `spi_master` block. It arbitrates between two client requesters and owns the master's chip-select.
- It also selects the per-client SCLK divider and sequences multi-byte frames, one `wr_req`/`wr_ack` byte handshake per byte.
- It sits between the application logic (ADC/DAC register access) and `spi_master`. No client ever drives `spi_master` directly.

## Interface
Parameters:
- `CS_SETUP`, 4: sys_clk cycles between cs falling and the first byte request (1..255).
- `CS_HOLD`, 4: cycles between the last byte's ack and cs rising (1..255).
- `CS_IDLE`, 2: minimum cs-high cycles between frames (1..255).

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` in 1: clock, shared with `spi_master`.
- `sys_rst` in 1: synchronous active-high reset.
- `req` in 2: per-client frame request. Level-sensitive; held until `done`.
- `len` in 8: per-client byte count minus 1. Client c uses `[4c+3:4c]`, giving frames of 1..16 bytes.
- `cfg_div` in 32: per-client SCLK divider. Client c uses `[16c+15:16c]`.
- `tx_data` in 16: per-client next TX byte, first-word-fall-through. Client c uses `[8c+7:8c]`.
- `tx_rd` out 2: one-cycle pop strobe to the granted client.
- `rx_data` out 8: registered received byte, shared by both clients.
- `rx_vld` out 2: one-cycle strobe qualifying `rx_data` for the granted client.
- `done` out 2: one-cycle end-of-frame strobe.
- `busy` out 1: high in every state except IDLE.
- `spi_cs_ctrl` out 1: drives master `cs_ctrl`. Active-low.
- `spi_clk_div_val` out 16: drives master `clk_div_val`.
- `spi_wr_req` out 1: drives master `wr_req`.
- `spi_wr_ack` in 1: from master `wr_ack`.
- `spi_data_tx` out 8: drives master `data_tx`.
- `spi_data_rx` in 8: from master `data_rx`. Valid in the `spi_wr_ack` cycle.

## Operation
States: IDLE, SETUP, LOAD, WAIT_ACK, GAP, HOLD, CSIDLE.

- **IDLE:** If any `req` bit is high, the arbiter selects grant g and the block latches:
  - `len` slice into the byte counter;
  - `cfg_div` slice into `spi_clk_div_val`;
  - g.
  
  It then drives `spi_cs_ctrl` to 0 and moves to SETUP.
- **SETUP:** Counts `CS_SETUP` cycles, then moves to LOAD.
- **LOAD (exactly one cycle):**
  - `spi_wr_req`=1;
  - `tx_rd[g]`=1;
  - `spi_data_tx` <= the `tx_data` slice of g.
  
  Then moves to WAIT_ACK.
- **WAIT_ACK:** On `spi_wr_ack`, latches `spi_data_rx` into `rx_data` and pulses `rx_vld[g]` in the following cycle.
  - If the byte counter is 0, go to HOLD.
  - Otherwise decrement the counter and go to GAP.
- **GAP (one cycle):** Moves to LOAD. This guarantees `spi_wr_req` next rises in cycle ack+2, when the master is back in its idle state.
- **HOLD:** Counts `CS_HOLD` cycles, then sets `spi_cs_ctrl` to 1 and moves to CSIDLE.
- **CSIDLE:** Counts `CS_IDLE` cycles, pulses `done[g]` in the final cycle, then returns to IDLE.

Rules:
- `spi_data_tx` stays stable from LOAD until ack.
- `spi_wr_req` is never high for more than one cycle.
- `req` dropping mid-frame is ignored; the frame completes.
- `len`/`cfg_div` changes after grant are ignored.
- `spi_wr_ack` outside WAIT_ACK is ignored.
- Counters are 8-bit and load from the parameter; the terminal value is 1. A byte counter of 4 bits covers 16 bytes.

## Timing
- Reset values:
  - `spi_cs_ctrl`=1;
  - `spi_wr_req`=0;
  - `tx_rd`=0, `rx_vld`=0, `done`=0, `busy`=0;
  - `rx_data`=0, `spi_data_tx`=0, `spi_clk_div_val`=0;
  - state IDLE; last-grant = client 1.
- Grant latency: `req` high in cycle n gives `spi_cs_ctrl` low in n+1 and the first `spi_wr_req` in n+1+`CS_SETUP`.
- Ack at cycle t:
  - `rx_vld` at t+1;
  - next `spi_wr_req` at t+2 (mid-frame);
  - `spi_cs_ctrl` high at t+1+`CS_HOLD` (last byte).
- Back-to-back frames: cs stays high for at least `CS_IDLE` cycles. The next grant is evaluated in the IDLE cycle after `done`.
- Reset mid-frame: all outputs return to reset values in the next cycle. `spi_master` shares the reset source (inverted to `sys_rst_n`), so it aborts at the same time.

## Configuration
- `SPI_XFER_SCHED_RR_EN` defined: round-robin between clients.
  - When both request, grant goes to the client not served last.
  - The last-grant register updates at each grant.
- Undefined: fixed priority, client 0 always wins, and the last-grant register is removed.
- Single requests are granted identically in both modes.

## Structure
- Package `spi_ctrl_pkg`:
  - state enum;
  - `SPI_NCLIENT`=2;
  - byte-width constants.
- Sub-module `spi_rr_arb2`: combinational grant from `req` plus the last-grant register, with the macro-selected policy.
- Top instantiates `spi_rr_arb2`, the FSM and the counters.

## Test plan
- **Single byte:** client 0, `len`=0, `tx_data`=0xA5, MISO loopback, `CS_SETUP`=4.
  - cs low one cycle after `req`;
  - one `spi_wr_req`;
  - `rx_data`=0xA5 with `rx_vld[0]`;
  - `done[0]` once; `busy` returns to 0.
- **4-byte frame:** client 1, `len`=3, `cfg_div`=2, bytes 0x01..0x04.
  - four `tx_rd[1]` pulses;
  - each `spi_wr_req` exactly 2 cycles after the previous ack;
  - `rx` bytes 0x01..0x04 in order;
  - cs continuous low for the whole frame.
- **Simultaneous requests, RR_EN defined:** both clients request 2 frames.
  - grant order 0,1,0,1;
  - `spi_clk_div_val` switches to the correct `cfg_div` per frame.
- **Simultaneous requests, RR_EN undefined:** client 0 holds `req` for 3 frames.
  - all three served before client 1.
- **Reset mid-frame:** assert `sys_rst` in WAIT_ACK of byte 2.
  - next cycle: cs=1, `spi_wr_req`=0, `busy`=0, no `done`;
  - a fresh request afterwards completes normally.
- **Inter-frame gap:** `CS_IDLE`=2, back-to-back requests.
  - cs high for at least 2 cycles between frames;
  - `req` dropped mid-frame still completes the frame with `done`.
